exu_bru_pred: RTL and testbench

EXU_BRU_PRED -- requirements
Module: exu_bru_pred

---
 rtl/alioth_bru_pkg.sv | 20 ++
 rtl/bru_upd_fifo.sv | 52 +++++
 rtl/exu_bru_pred.sv | 140 ++++++++++++++
 tb/tb_exu_bru_pred.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alioth_bru_pkg.sv
// Shared definitions for the EX-stage branch unit: op_i bit positions and
// the redirect/squash state encoding.
package alioth_bru_pkg;

  localparam int OP_JAL  = 0;
  localparam int OP_JALR = 1;
  localparam int OP_BEQ  = 2;
  localparam int OP_BNE  = 3;
  localparam int OP_BLT  = 4;
  localparam int OP_BGE  = 5;
  localparam int OP_BLTU = 6;
  localparam int OP_BGEU = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REDIR = 2'd1,
    ST_KILL  = 2'd2
  } bru_state_e;

endpackage

// File: rtl/bru_upd_fifo.sv
// First-word fall-through queue carrying resolved branch outcomes to the predictor.
// A push into a full queue is dropped unless a pop frees a slot in the same cycle.
module bru_upd_fifo #(
  parameter int W     = 65,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic         overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         empty;
  logic         full;
  logic         pop;
  logic         wr_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign valid = ~empty;
  assign pop   = valid & ready;
  assign wr_en = push & (~full | pop);

  // Output gated to zero while empty so nothing stale leaks out of reset.
  assign dout  = valid ? mem[rd_ptr[AW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      overflow <= push & full & ~pop;
    end
  end

endmodule

// File: rtl/exu_bru_pred.sv
// EX-stage branch resolution: checks the front-end prediction, issues a one-cycle
// redirect followed by a wrong-path squash, and queues predictor updates.
module exu_bru_pred
  import alioth_bru_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int C_EXT     = 0,
  parameter int KILL_CYC  = 2,
  parameter int UPD_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_i,
  input  logic [7:0]      op_i,
  input  logic            fence_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic            pred_taken_i,
  input  logic [XLEN-1:0] pred_target_i,
  input  logic            stall_i,
  input  logic            int_assert_i,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_addr_o,
  output logic            misaligned_o,
  output logic            kill_o,
  output logic            upd_valid_o,
  input  logic            upd_ready_i,
  output logic [XLEN-1:0] upd_pc_o,
  output logic [XLEN-1:0] upd_target_o,
  output logic            upd_taken_o,
  output logic            upd_overflow_o,
  output logic [1:0]      dbg_state_o
);

  localparam int UW = 2 * XLEN + 1;

  bru_state_e      state;
  logic [3:0]      cnt;
  logic [XLEN-1:0] sum_pc;
  logic [XLEN-1:0] sum_jr;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] fall_thru;
  logic            eq;
  logic            lt_s;
  logic            lt_u;
  logic            taken;
  logic            misalign;
  logic            accept;
  logic            mis_hit;
  logic            mispred;
  logic            redir_go;
  logic            push;
  logic [UW-1:0]   upd_word;

  assign sum_pc    = pc_i + imm_i;
  assign sum_jr    = op1_i + imm_i;
  assign target    = op_i[OP_JALR] ? (sum_jr & {{(XLEN-1){1'b1}}, 1'b0}) : sum_pc;
  assign fall_thru = pc_i + XLEN'(4);

  assign eq   = (op1_i == op2_i);
  assign lt_s = ($signed(op1_i) < $signed(op2_i));
  assign lt_u = (op1_i < op2_i);

  assign taken = op_i[OP_JAL] | op_i[OP_JALR]
               | (op_i[OP_BEQ]  &  eq)   | (op_i[OP_BNE]  & ~eq)
               | (op_i[OP_BLT]  &  lt_s) | (op_i[OP_BGE]  & ~lt_s)
               | (op_i[OP_BLTU] &  lt_u) | (op_i[OP_BGEU] & ~lt_u);

  assign misalign = (C_EXT != 0) ? target[0] : (target[1:0] != 2'b00);

  // Valid/ready: a request is taken when req_i is high, the pipe is not stalled and
  // the EX instruction is not on the wrong path; the update queue pops on
  // upd_valid_o & upd_ready_i and its head is visible before the pop.
  assign accept   = req_i & ~stall_i & ~kill_o;
  assign mis_hit  = ~fence_i & taken & misalign;
  assign mispred  = fence_i | (taken != pred_taken_i) | (taken & (target != pred_target_i));
  assign redir_go = accept & mispred & ~mis_hit & ~int_assert_i;
  assign push     = accept & ~fence_i & (|op_i) & ~mis_hit & ~int_assert_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      cnt             <= 4'd0;
      redirect_addr_o <= '0;
      misaligned_o    <= 1'b0;
    end else begin
      misaligned_o <= accept & mis_hit & ~int_assert_i;
      case (state)
        ST_IDLE: begin
          if (redir_go) begin
            state           <= ST_REDIR;
            redirect_addr_o <= (~fence_i & taken) ? target : fall_thru;
          end
        end
        // The redirect leaves regardless of stall_i so it is never lost.
        ST_REDIR: begin
          state <= ST_KILL;
          cnt   <= 4'd1;
        end
        ST_KILL: begin
          if (cnt == 4'(KILL_CYC)) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign redirect_valid_o = (state == ST_REDIR);
  assign kill_o           = (state != ST_IDLE);
  assign dbg_state_o      = state;

  bru_upd_fifo #(
    .W     (UW),
    .DEPTH (UPD_DEPTH)
  ) u_upd_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .din      ({pc_i, taken, target}),
    .ready    (upd_ready_i),
    .valid    (upd_valid_o),
    .dout     (upd_word),
    .overflow (upd_overflow_o)
  );

  assign upd_pc_o     = upd_word[UW-1 -: XLEN];
  assign upd_taken_o  = upd_word[XLEN];
  assign upd_target_o = upd_word[XLEN-1:0];

endmodule

// File: tb/tb_exu_bru_pred.sv
// Directed and randomised checks of branch resolution, redirect/squash timing
// and the predictor-update queue of exu_bru_pred.
module tb_exu_bru_pred;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [7:0]  op = 8'h00;
  logic        fence = 1'b0;
  logic [31:0] op1 = '0, op2 = '0, pc = '0, imm = '0, ptgt = '0;
  logic        pt = 1'b0, stall = 1'b0, intr = 1'b0, upd_ready = 1'b0;
  logic        redirect_valid, misaligned, kill, upd_valid, upd_taken, upd_overflow;
  logic [31:0] redirect_addr, upd_pc, upd_target;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [64:0] exp_q[$];
  logic        exp_redir, exp_mis, exp_ovf;
  logic [31:0] exp_addr;

  localparam logic [7:0] JAL = 8'h01, JALR = 8'h02, BEQ = 8'h04, BNE = 8'h08,
                         BLT = 8'h10, BGE = 8'h20, BLTU = 8'h40, BGEU = 8'h80;

  exu_bru_pred dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .op_i(op), .fence_i(fence),
    .op1_i(op1), .op2_i(op2), .pc_i(pc), .imm_i(imm),
    .pred_taken_i(pt), .pred_target_i(ptgt), .stall_i(stall), .int_assert_i(intr),
    .redirect_valid_o(redirect_valid), .redirect_addr_o(redirect_addr),
    .misaligned_o(misaligned), .kill_o(kill),
    .upd_valid_o(upd_valid), .upd_ready_i(upd_ready), .upd_pc_o(upd_pc),
    .upd_target_o(upd_target), .upd_taken_o(upd_taken), .upd_overflow_o(upd_overflow),
    .dbg_state_o(dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  function automatic void model(input logic [7:0] o, input logic [31:0] a, b, p, im,
                                output logic tk, output logic [31:0] tg);
    tg = (o == JALR) ? ((a + im) & 32'hFFFF_FFFE) : (p + im);
    case (o)
      JAL, JALR: tk = 1'b1;
      BEQ:  tk = (a == b);
      BNE:  tk = (a != b);
      BLT:  tk = ($signed(a) < $signed(b));
      BGE:  tk = ($signed(a) >= $signed(b));
      BLTU: tk = (a < b);
      BGEU: tk = (a >= b);
      default: tk = 1'b0;
    endcase
  endfunction

  // Driver: one request in one cycle; expectations derived from the model.
  // Assumes the unit is idle and upd_ready is low while issuing.
  task automatic issue(input logic [7:0] o, input logic f, input logic [31:0] a, b, p, im,
                       input logic t, input logic [31:0] tgp, input logic it);
    logic        tk, mis, mp, pu;
    logic [31:0] tg;
    model(o, a, b, p, im, tk, tg);
    mis       = ~f & tk & (tg[1:0] != 2'b00);
    mp        = f | (tk != t) | (tk & (tg != tgp));
    exp_redir = ~stall & mp & ~mis & ~it;
    exp_addr  = (~f & tk) ? tg : p + 32'd4;
    exp_mis   = ~stall & mis & ~it;
    pu        = ~stall & ~f & (o != 8'h00) & ~mis & ~it;
    exp_ovf   = 1'b0;
    if (pu) begin
      if (exp_q.size() >= 4) exp_ovf = 1'b1;
      else exp_q.push_back({p, tk, tg});
    end
    @(negedge clk);
    req = 1'b1; op = o; fence = f; op1 = a; op2 = b; pc = p; imm = im;
    pt = t; ptgt = tgp; intr = it;
    @(negedge clk);
    req = 1'b0; fence = 1'b0; intr = 1'b0; op = 8'h00;
  endtask

  // Count squash and redirect cycles from the current negedge until kill drops.
  task automatic wait_kill(output int kc, output int rc);
    int guard = 0;
    kc = 0; rc = 0;
    while (kill && guard < 40) begin
      kc++;
      if (redirect_valid) rc++;
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (kill) begin
      n_errors++;
      $display("FAIL kill_timeout: kill_o still %0b after %0d cycles, required 0", kill, guard);
    end
  endtask

  // Scoreboard: pop expected updates and compare against the queue head.
  task automatic drain_updates(input string name);
    logic [64:0] e;
    int guard = 0;
    upd_ready = 1'b1;
    while (exp_q.size() > 0 && guard < 40) begin
      if (upd_valid) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({upd_pc, upd_taken, upd_target} !== e) begin
          n_errors++;
          $display("FAIL %s_upd: got pc=%h tk=%0b tgt=%h, required pc=%h tk=%0b tgt=%h",
                   name, upd_pc, upd_taken, upd_target, e[64:33], e[32], e[31:0]);
        end
      end
      @(negedge clk);
      guard++;
    end
    upd_ready = 1'b0;
    n_checks++;
    if (exp_q.size() != 0 || upd_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL %s_drain: %0d updates missing, upd_valid_o=%0b, required 0 and 0",
               name, exp_q.size(), upd_valid);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({redirect_valid, misaligned, kill, upd_valid, upd_overflow, upd_taken} !== 6'b0 ||
        redirect_addr !== 32'h0 || upd_pc !== 32'h0 || upd_target !== 32'h0 || dbg_state !== 2'd0) begin
      n_errors++;
      $display("FAIL reset: rv=%0b mis=%0b kill=%0b uv=%0b ovf=%0b addr=%h st=%0d, required all 0",
               redirect_valid, misaligned, kill, upd_valid, upd_overflow, redirect_addr, dbg_state);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_beq_mispredict();
    int kc, rc;
    issue(BEQ, 0, 5, 5, 32'h100, 32'h20, 0, 32'h0, 0);
    n_checks++;
    if (redirect_valid !== 1'b1 || redirect_addr !== 32'h120) begin
      n_errors++;
      $display("FAIL beq_redir: rv=%0b addr=%h, required 1 and 00000120", redirect_valid, redirect_addr);
    end
    wait_kill(kc, rc);
    n_checks++;
    if (kc != 3 || rc != 1) begin
      n_errors++;
      $display("FAIL beq_kill: kill %0d cycles redirect %0d cycles, required 3 and 1", kc, rc);
    end
    drain_updates("beq");
  endtask

  task automatic test_bne_not_taken();
    int kc, rc;
    issue(BNE, 0, 9, 9, 32'h200, 32'h40, 1, 32'h240, 0);
    n_checks++;
    if (redirect_valid !== 1'b1 || redirect_addr !== 32'h204) begin
      n_errors++;
      $display("FAIL bne_redir: rv=%0b addr=%h, required 1 and 00000204", redirect_valid, redirect_addr);
    end
    wait_kill(kc, rc);
    drain_updates("bne");
  endtask

  task automatic test_misaligned();
    issue(JALR, 0, 32'h1003, 0, 32'h300, 32'h0, 0, 32'h0, 0);
    n_checks++;
    if (misaligned !== 1'b1 || redirect_valid !== 1'b0 || kill !== 1'b0) begin
      n_errors++;
      $display("FAIL mis_pulse: mis=%0b rv=%0b kill=%0b, required 1 0 0", misaligned, redirect_valid, kill);
    end
    @(negedge clk);
    n_checks++;
    if (misaligned !== 1'b0 || upd_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL mis_after: mis=%0b uv=%0b, required 0 0", misaligned, upd_valid);
    end
  endtask

  task automatic test_correct_pred();
    issue(BEQ, 0, 7, 7, 32'h100, 32'h20, 1, 32'h120, 0);
    n_checks++;
    if (redirect_valid !== 1'b0 || kill !== 1'b0 || upd_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL correct_pred: rv=%0b kill=%0b uv=%0b, required 0 0 1", redirect_valid, kill, upd_valid);
    end
    drain_updates("correct");
  endtask

  task automatic test_overflow();
    logic [31:0] p, im;
    for (int i = 0; i < 5; i++) begin
      p  = 32'($urandom_range(0, 1023)) * 4;
      im = 32'($urandom_range(1, 255)) * 4;
      issue(JAL, 0, 0, 0, p, im, 1, p + im, 0);
      n_checks++;
      if (upd_overflow !== exp_ovf) begin
        n_errors++;
        $display("FAIL ovf_push%0d: upd_overflow_o=%0b, required %0b", i, upd_overflow, exp_ovf);
      end
    end
    @(negedge clk);
    n_checks++;
    if (upd_overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL ovf_pulse: upd_overflow_o=%0b one cycle later, required 0", upd_overflow);
    end
    drain_updates("ovf");
  endtask

  task automatic test_int_assert();
    issue(BEQ, 0, 1, 1, 32'h500, 32'h10, 0, 32'h0, 1);
    n_checks++;
    if (redirect_valid !== 1'b0 || kill !== 1'b0 || upd_valid !== 1'b0 || misaligned !== 1'b0) begin
      n_errors++;
      $display("FAIL int_assert: rv=%0b kill=%0b uv=%0b mis=%0b, required 0 0 0 0",
               redirect_valid, kill, upd_valid, misaligned);
    end
  endtask

  task automatic test_fence();
    int kc, rc;
    issue(8'h00, 1, 0, 0, 32'h300, 32'h0, 0, 32'h0, 0);
    n_checks++;
    if (redirect_valid !== 1'b1 || redirect_addr !== 32'h304 || upd_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL fence: rv=%0b addr=%h uv=%0b, required 1 00000304 0", redirect_valid, redirect_addr, upd_valid);
    end
    wait_kill(kc, rc);
  endtask

  task automatic test_stall();
    int kc, rc;
    stall = 1'b1;
    issue(BEQ, 0, 3, 3, 32'h600, 32'h40, 0, 32'h0, 0);
    n_checks++;
    if (redirect_valid !== 1'b0 || kill !== 1'b0 || upd_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL stall_ignore: rv=%0b kill=%0b uv=%0b, required 0 0 0", redirect_valid, kill, upd_valid);
    end
    stall = 1'b0;
    issue(BEQ, 0, 3, 3, 32'h600, 32'h40, 0, 32'h0, 0);
    stall = 1'b1;
    wait_kill(kc, rc);
    stall = 1'b0;
    n_checks++;
    if (kc != 3 || rc != 1 || redirect_addr !== 32'h640) begin
      n_errors++;
      $display("FAIL stall_redir: kill %0d rv %0d addr=%h, required 3 1 00000640", kc, rc, redirect_addr);
    end
    drain_updates("stall");
  endtask

  task automatic test_back_to_back();
    int kc, rc;
    @(negedge clk);
    req = 1'b1; op = BNE; op1 = 4; op2 = 4; pc = 32'h400; imm = 32'h8; pt = 1'b1; ptgt = 32'h408;
    exp_q.push_back({32'h400, 1'b0, 32'h408});
    @(negedge clk);
    n_checks++;
    if (redirect_valid !== 1'b1 || redirect_addr !== 32'h404) begin
      n_errors++;
      $display("FAIL b2b_first: rv=%0b addr=%h, required 1 00000404", redirect_valid, redirect_addr);
    end
    op = BEQ; pc = 32'h500; imm = 32'h80; pt = 1'b0;
    @(negedge clk);
    req = 1'b0; op = 8'h00;
    wait_kill(kc, rc);
    n_checks++;
    if (kc != 2 || rc != 0 || redirect_addr !== 32'h404) begin
      n_errors++;
      $display("FAIL b2b_second: kill %0d rv %0d addr=%h, required 2 0 00000404", kc, rc, redirect_addr);
    end
    drain_updates("b2b");
  endtask

  task automatic test_random();
    logic [7:0]  ops [7];
    logic [31:0] vals [4];
    logic [7:0]  o;
    logic [31:0] a, b, p, im, tg;
    logic        tk, t;
    int          kc, rc;
    ops  = '{BEQ, BNE, BLT, BGE, BLTU, BGEU, JAL};
    vals = '{32'd5, 32'd5, 32'hFFFF_FFF0, 32'd7};
    for (int i = 0; i < 10; i++) begin
      o  = ops[$urandom_range(0, 6)];
      a  = vals[$urandom_range(0, 3)];
      b  = vals[$urandom_range(0, 3)];
      p  = 32'($urandom_range(0, 1023)) * 4;
      im = 32'($urandom_range(0, 255)) * 4;
      t  = 1'($urandom_range(0, 1));
      model(o, a, b, p, im, tk, tg);
      issue(o, 0, a, b, p, im, t, ($urandom_range(0, 1) != 0) ? tg : tg + 32'd4, 0);
      n_checks++;
      if (redirect_valid !== exp_redir || (exp_redir && redirect_addr !== exp_addr)) begin
        n_errors++;
        $display("FAIL rand%0d: op=%h rv=%0b addr=%h, required %0b %h", i, o, redirect_valid,
                 redirect_addr, exp_redir, exp_addr);
      end
      wait_kill(kc, rc);
      drain_updates("rand");
    end
  endtask

  task automatic test_reset_mid_kill();
    issue(BEQ, 0, 2, 2, 32'h700, 32'h10, 0, 32'h0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    n_checks++;
    if (kill !== 1'b0 || redirect_valid !== 1'b0 || upd_valid !== 1'b0 || dbg_state !== 2'd0) begin
      n_errors++;
      $display("FAIL reset_kill: kill=%0b rv=%0b uv=%0b st=%0d, required 0 0 0 0",
               kill, redirect_valid, upd_valid, dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_beq_mispredict();
    test_bne_not_taken();
    test_misaligned();
    test_correct_pred();
    test_overflow();
    test_int_assert();
    test_fence();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_mid_kill();
    test_beq_mispredict();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
